// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment display controller.
//   - SEG_HEX_0 .. SEG_HEX_F : active-low segment patterns {a,b,c,d,e,f,g},
//                             segment a in bit 6
//   - SEG_BLANK              : all segments off
//   - entry_t                : one digit register {blank, dp, nibble}
//   - ENTRY_RESET            : value every digit register takes on reset/clear
//   - hexToSeg()             : nibble to segment pattern lookup
// No ports; imported by seg7_hex_decode and seg7_scan_ctrl.
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One digit register. dp is stored as "lit" (1 = point on); the
  // active-low inversion happens at the output register.
  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] nibble;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{blank: 1'b1, dp: 1'b0, nibble: 4'h0};

  // Plain lookup of the sixteen hex glyphs.
  function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
    logic [6:0] segPattern;
    case (nibble)
      4'h0:    segPattern = SEG_HEX_0;
      4'h1:    segPattern = SEG_HEX_1;
      4'h2:    segPattern = SEG_HEX_2;
      4'h3:    segPattern = SEG_HEX_3;
      4'h4:    segPattern = SEG_HEX_4;
      4'h5:    segPattern = SEG_HEX_5;
      4'h6:    segPattern = SEG_HEX_6;
      4'h7:    segPattern = SEG_HEX_7;
      4'h8:    segPattern = SEG_HEX_8;
      4'h9:    segPattern = SEG_HEX_9;
      4'hA:    segPattern = SEG_HEX_A;
      4'hB:    segPattern = SEG_HEX_B;
      4'hC:    segPattern = SEG_HEX_C;
      4'hD:    segPattern = SEG_HEX_D;
      4'hE:    segPattern = SEG_HEX_E;
      default: segPattern = SEG_HEX_F;
    endcase
    return segPattern;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Bundles the write port and the display outputs of seg7_scan_ctrl.
//   Write side : wr_en, wr_addr[AW], wr_data[4], wr_blank, clr, bright[3]
//   Display    : seg[7] (active-low), dig_n[NUM_DIGITS] (one-hot-low),
//                scan_idx[AW], frame_done
//   SEG7_DP_EN : adds wr_dp (write side) and dp (active-low display output)
// Modports: master = data producer, slave = the display controller.
// ---------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;
  logic                  wr_blank;
  logic                  clr;
  logic [2:0]            bright;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] dig_n;
  logic [AW-1:0]         scan_idx;
  logic                  frame_done;
`ifdef SEG7_DP_EN
  logic                  wr_dp;
  logic                  dp;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, wr_blank, clr, bright,
`ifdef SEG7_DP_EN
    output wr_dp,
    input  dp,
`endif
    input  seg, dig_n, scan_idx, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_blank, clr, bright,
`ifdef SEG7_DP_EN
    input  wr_dp,
    output dp,
`endif
    output seg, dig_n, scan_idx, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to active-low seven-segment pattern.
//   nibble_i [4] : hex value 0..F
//   seg_o    [7] : {a,b,c,d,e,f,g}, active-low, a = bit 6
// ---------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure lookup; blanking is decided by the caller.
  always_comb begin
    seg_o = hexToSeg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Multiplexed seven-segment display controller. Holds one register per digit
// and scans them onto a shared active-low segment bus at SCAN_DIV clocks per
// digit, with PWM brightness, a dark first cycle in every slot to stop
// ghosting between digits, and a pulse at the end of every frame.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seg7_scan_ctrl_if.slave (write port in, seg/dig_n/scan_idx/
//          frame_done out; wr_dp/dp when SEG7_DP_EN is defined)
// Parameters: NUM_DIGITS (2..16), SCAN_DIV (multiple of 8, >= 8).
// Optional feature macro: SEG7_DP_EN (per-digit decimal point).
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [AW-1:0]         scanIdx_q, scanIdx_d;
  logic                  running_q;
  entry_t                regFile_q [NUM_DIGITS];
  entry_t                wrEntry;
  logic                  wrAddrValid;
  logic [31:0]           onThresh;
  logic                  onWindow;
  logic [6:0]            decSeg;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digN_q, digN_d;
  logic [AW-1:0]         scanIdxOut_q;
  logic                  frameDone_q, frameDone_d;
`ifdef SEG7_DP_EN
  logic                  dp_q, dp_d;
`endif

  // Shape the incoming write into a register entry and reject addresses
  // beyond the last digit (possible when NUM_DIGITS is not a power of two).
  always_comb begin
    wrEntry        = ENTRY_RESET;
    wrEntry.blank  = bus.wr_blank;
    wrEntry.nibble = bus.wr_data;
`ifdef SEG7_DP_EN
    wrEntry.dp     = bus.wr_dp;
`endif
    wrAddrValid    = ({1'b0, bus.wr_addr} < (AW+1)'(NUM_DIGITS));
  end

  // Digit register file. Clear takes priority over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        regFile_q[i] <= ENTRY_RESET;
      end
    end else if (bus.wr_en && wrAddrValid) begin
      regFile_q[bus.wr_addr] <= wrEntry;
    end
  end

  // Prescaler and digit index. running_q holds the counters at zero for the
  // first edge after reset so slot 0 starts with a full-length dark cycle.
  always_comb begin
    pcnt_d    = pcnt_q;
    scanIdx_d = scanIdx_q;
    if (running_q) begin
      if (pcnt_q == PW'(SCAN_DIV - 1)) begin
        pcnt_d    = '0;
        scanIdx_d = (scanIdx_q == AW'(NUM_DIGITS - 1)) ? '0 : scanIdx_q + 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // The on-window is 1 <= pcnt < (bright+1)*SCAN_DIV/8; bright is live so a
  // change lands mid-slot. pcnt == 0 always stays dark.
  always_comb begin
    onThresh = (32'(bus.bright) + 32'd1) * 32'(SCAN_DIV / 8);
    onWindow = (pcnt_q != '0) && (32'(pcnt_q) < onThresh);
  end

  seg7_hex_decode uHexDecode (
    .nibble_i (regFile_q[scanIdx_q].nibble),
    .seg_o    (decSeg)
  );

  // Next output values from the current slot. A blank entry still drives its
  // digit enable but shows no segments.
  always_comb begin
    seg_d  = SEG_BLANK;
    digN_d = '1;
`ifdef SEG7_DP_EN
    dp_d   = 1'b1;
`endif
    if (onWindow) begin
      digN_d[scanIdx_q] = 1'b0;
      if (!regFile_q[scanIdx_q].blank) begin
        seg_d = decSeg;
`ifdef SEG7_DP_EN
        dp_d  = ~regFile_q[scanIdx_q].dp;
`endif
      end
    end
    frameDone_d = (pcnt_q == PW'(SCAN_DIV - 1)) &&
                  (scanIdx_q == AW'(NUM_DIGITS - 1));
  end

  // Counters and output registers; every output lags the counters by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      running_q    <= 1'b0;
      pcnt_q       <= '0;
      scanIdx_q    <= '0;
      seg_q        <= SEG_BLANK;
      digN_q       <= '1;
      scanIdxOut_q <= '0;
      frameDone_q  <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q         <= 1'b1;
`endif
    end else begin
      running_q    <= 1'b1;
      pcnt_q       <= pcnt_d;
      scanIdx_q    <= scanIdx_d;
      seg_q        <= seg_d;
      digN_q       <= digN_d;
      scanIdxOut_q <= scanIdx_q;
      frameDone_q  <= frameDone_d;
`ifdef SEG7_DP_EN
      dp_q         <= dp_d;
`endif
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_n      = digN_q;
  assign bus.scan_idx   = scanIdxOut_q;
  assign bus.frame_done = frameDone_q;
`ifdef SEG7_DP_EN
  assign bus.dp         = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8.
// A directed table walks through writes, brightness changes, clear priority,
// frame end and a mid-frame reset; a randomized phase follows. Every cycle is
// compared against a reference model that derives the scan position from the
// number of edges since reset. Honours SEG7_DP_EN for the decimal point.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  logic rst;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Glyph table written straight from the display encoding list.
  logic [6:0] hexRef [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int vectors;
  int miscompares;

  // Reference model state: edges since reset release and the digit contents.
  int         edgeNum;
  logic       mBlank [N];
  logic [3:0] mNib   [N];
  logic       mDp    [N];

  typedef struct {
    logic       rst;
    logic       wrEn;
    logic [1:0] addr;
    logic [3:0] data;
    logic       blank;
    logic       dpIn;
    logic       clr;
    logic [2:0] bright;
    int         cycles;
    logic [6:0] expSeg;
    logic [3:0] expDig;
    logic [1:0] expIdx;
    logic       expFd;
    logic       expDp;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mkVec(
    input logic r, input logic we, input logic [1:0] addr, input logic [3:0] data,
    input logic blank, input logic dpIn, input logic c, input logic [2:0] br,
    input int cycles, input logic [6:0] eSeg, input logic [3:0] eDig,
    input logic [1:0] eIdx, input logic eFd, input logic eDp);
    vec_t v;
    v.rst = r; v.wrEn = we; v.addr = addr; v.data = data; v.blank = blank;
    v.dpIn = dpIn; v.clr = c; v.bright = br; v.cycles = cycles;
    v.expSeg = eSeg; v.expDig = eDig; v.expIdx = eIdx; v.expFd = eFd; v.expDp = eDp;
    return v;
  endfunction

  // Compare the registered outputs with one set of expected values.
  task automatic checkOutput(input string tag, input logic [6:0] eSeg,
                             input logic [N-1:0] eDig, input logic [1:0] eIdx,
                             input logic eFd, input logic eDp);
    vectors++;
    if (bus.seg !== eSeg) begin
      miscompares++;
      $display("[TB] FAIL %s seg: got %b expected %b", tag, bus.seg, eSeg);
    end
    if (bus.dig_n !== eDig) begin
      miscompares++;
      $display("[TB] FAIL %s dig_n: got %b expected %b", tag, bus.dig_n, eDig);
    end
    if (bus.scan_idx !== eIdx) begin
      miscompares++;
      $display("[TB] FAIL %s scan_idx: got %0d expected %0d", tag, bus.scan_idx, eIdx);
    end
    if (bus.frame_done !== eFd) begin
      miscompares++;
      $display("[TB] FAIL %s frame_done: got %b expected %b", tag, bus.frame_done, eFd);
    end
`ifdef SEG7_DP_EN
    if (bus.dp !== eDp) begin
      miscompares++;
      $display("[TB] FAIL %s dp: got %b expected %b", tag, bus.dp, eDp);
    end
`else
    if (eDp !== 1'b1) begin
      $display("[TB] note: dp expectation %b ignored without decimal point", eDp);
    end
`endif
  endtask

  // Drive one cycle of inputs, clock it, then predict and check the outputs.
  // The model places edge e at scan position e-1 (position 0 for e=0), takes
  // slot = position / DIV and pcnt = position % DIV, and applies writes after
  // the prediction because outputs show the register file before this edge.
  task automatic applyStimulus(input logic r, input logic we, input logic [1:0] addr,
                               input logic [3:0] data, input logic blank, input logic dpIn,
                               input logic c, input logic [2:0] br, input string tag);
    logic [6:0]   eSeg;
    logic [N-1:0] eDig;
    logic [1:0]   eIdx;
    logic         eFd;
    logic         eDp;
    int           pos;
    int           slotPos;
    int           digit;
    bit           lit;
    rst          = r;
    bus.wr_en    = we;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    bus.wr_blank = blank;
    bus.clr      = c;
    bus.bright   = br;
`ifdef SEG7_DP_EN
    bus.wr_dp    = dpIn;
`endif
    @(posedge clk);
    #1;
    eSeg = 7'h7F;
    eDig = '1;
    eIdx = 2'd0;
    eFd  = 1'b0;
    eDp  = 1'b1;
    if (r) begin
      edgeNum = -1;
      for (int i = 0; i < N; i++) begin
        mBlank[i] = 1'b1; mNib[i] = 4'h0; mDp[i] = 1'b0;
      end
    end else begin
      edgeNum++;
      pos     = (edgeNum == 0) ? 0 : edgeNum - 1;
      slotPos = pos % DIV;
      digit   = (pos / DIV) % N;
      lit     = (slotPos >= 1) && (slotPos < (int'(br) + 1) * (DIV / 8));
      eIdx    = 2'(digit);
      eFd     = (edgeNum > 0) && (edgeNum % FRAME == 0);
      if (lit) begin
        eDig[digit] = 1'b0;
        if (!mBlank[digit]) begin
          eSeg = hexRef[mNib[digit]];
          eDp  = ~mDp[digit];
        end
      end
      if (c) begin
        for (int i = 0; i < N; i++) begin
          mBlank[i] = 1'b1; mNib[i] = 4'h0; mDp[i] = 1'b0;
        end
      end else if (we && int'(addr) < N) begin
        mBlank[addr] = blank; mNib[addr] = data; mDp[addr] = dpIn;
      end
    end
    checkOutput(tag, eSeg, eDig, eIdx, eFd, eDp);
  endtask

  initial begin
    logic       rR, rWe, rBlank, rDp, rClr;
    logic [1:0] rAddr;
    logic [3:0] rData;
    logic [2:0] rBright;

    vectors     = 0;
    miscompares = 0;
    edgeNum     = -1;
    for (int i = 0; i < N; i++) begin
      mBlank[i] = 1'b1; mNib[i] = 4'h0; mDp[i] = 1'b0;
    end
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_blank = 1'b0;
    bus.clr      = 1'b0;
    bus.bright   = 3'd7;
`ifdef SEG7_DP_EN
    bus.wr_dp    = 1'b0;
`endif

    // rst we addr data blk dp clr br cyc | seg dig idx fd dp  (checked on last cycle)
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 7,  2, 7'h7F, 4'b1111, 0, 0, 1)); // reset
    vecs.push_back(mkVec(0, 1, 0, 1, 0, 0, 0, 7,  1, 7'h7F, 4'b1111, 0, 0, 1)); // e0 dark
    vecs.push_back(mkVec(0, 1, 1, 2, 0, 1, 0, 7,  1, 7'h7F, 4'b1111, 0, 0, 1)); // e1 pcnt 0
    vecs.push_back(mkVec(0, 1, 2, 3, 0, 0, 0, 7,  1, 7'h4F, 4'b1110, 0, 0, 1)); // e2 digit 0 on
    vecs.push_back(mkVec(0, 1, 3, 4, 0, 0, 0, 7,  1, 7'h4F, 4'b1110, 0, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  5, 7'h4F, 4'b1110, 0, 0, 1)); // pcnt 7 still on
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h7F, 4'b1111, 1, 0, 1)); // slot 1 ghost gap
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h12, 4'b1101, 1, 0, 0)); // digit 1 with dp
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 3,  2, 7'h12, 4'b1101, 1, 0, 0)); // bright 3, pcnt 3
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 3,  1, 7'h7F, 4'b1111, 1, 0, 1)); // bright 3, pcnt 4
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 3,  4, 7'h7F, 4'b1111, 2, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0,  1, 7'h7F, 4'b1111, 2, 0, 1)); // bright 0 dark
    vecs.push_back(mkVec(0, 1, 2, 5, 0, 0, 1, 7,  1, 7'h06, 4'b1011, 2, 0, 1)); // clr + wr_en
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h7F, 4'b1011, 2, 0, 1)); // clr won
    vecs.push_back(mkVec(0, 1, 2, 5, 0, 0, 0, 7,  1, 7'h7F, 4'b1011, 2, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h24, 4'b1011, 2, 0, 1)); // live write shows
    vecs.push_back(mkVec(0, 1, 2, 9, 1, 1, 0, 7,  1, 7'h24, 4'b1011, 2, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h7F, 4'b1011, 2, 0, 1)); // blanked entry
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  8, 7'h7F, 4'b0111, 3, 1, 1)); // frame end
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h7F, 4'b1111, 0, 0, 1)); // wrapped
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7, 18, 7'h7F, 4'b1011, 2, 0, 1)); // into slot 2
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 7,  1, 7'h7F, 4'b1111, 0, 0, 1)); // mid-frame rst
    vecs.push_back(mkVec(0, 1, 0, 8, 0, 0, 0, 7,  1, 7'h7F, 4'b1111, 0, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h7F, 4'b1111, 0, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 7,  1, 7'h00, 4'b1110, 0, 0, 1)); // digit 0 at e2

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].cycles; c++) begin
        applyStimulus(vecs[k].rst, vecs[k].wrEn, vecs[k].addr, vecs[k].data,
                      vecs[k].blank, vecs[k].dpIn, vecs[k].clr, vecs[k].bright,
                      $sformatf("row%0d model", k));
      end
      checkOutput($sformatf("row%0d table", k), vecs[k].expSeg, vecs[k].expDig,
                  vecs[k].expIdx, vecs[k].expFd, vecs[k].expDp);
    end

    // Randomized traffic: sparse resets and clears, frequent writes, and
    // occasional brightness changes that land anywhere in a slot.
    rBright = 3'd5;
    for (int n = 0; n < 2000; n++) begin
      rR     = ($urandom_range(99) == 0);
      rClr   = ($urandom_range(19) == 0);
      rWe    = ($urandom_range(2) == 0);
      rAddr  = 2'($urandom_range(3));
      rData  = 4'($urandom_range(15));
      rBlank = ($urandom_range(3) == 0);
      rDp    = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) begin
        rBright = 3'($urandom_range(7));
      end
      applyStimulus(rR, rWe, rAddr, rData, rBlank, rDp, rClr, rBright, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
